paralelo_serial_flujo: RTL

Parametrised parallel-to-serial converter with a valid/ready input handshake and a one-word holding buffer, so back-to-back words serialise with no gap. Frames are free-running: every ANCHO clocks a new word starts. If no data is pending, a programmable idle pattern (K28.5 comma by default) is sent instead. Sits between the 8b/10b encoder and the serial line; the deserialiser uses inicioPalabra/idle for alignment checks.

---
 rtl/paralelo_serial_flujo_pkg.sv | 11 +
 rtl/paralelo_serial_flujo_if.sv | 20 ++
 rtl/paralelo_serial_flujo_contador_modulo.sv | 22 ++
 rtl/paralelo_serial_flujo.sv | 71 +++++++
 4 files changed

// File: rtl/paralelo_serial_flujo_pkg.sv
// Shared constants for the serialiser/deserialiser pair: default word width,
// K28.5 comma codes and the bit-counter width helper.
package paralelo_serial_flujo_pkg;
  localparam int         ANCHO_DEF = 10;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  function automatic int ancho_cuenta(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/paralelo_serial_flujo_if.sv
// Producer-side handshake plus serial line outputs of the serialiser.
interface paralelo_serial_flujo_if #(
  parameter int ANCHO = paralelo_serial_flujo_pkg::ANCHO_DEF
);
  logic [ANCHO-1:0] entradas;
  logic             validEntrada;
  logic             listoEntrada;
  logic             salida;
  logic             inicioPalabra;
  logic             enviandoDatos;

  modport master (
    output entradas, validEntrada,
    input  listoEntrada, salida, inicioPalabra, enviandoDatos
  );
  modport slave (
    input  entradas, validEntrada,
    output listoEntrada, salida, inicioPalabra, enviandoDatos
  );
endinterface

// File: rtl/paralelo_serial_flujo_contador_modulo.sv
// Free-running modulo-N counter with programmable reset value and a strobe
// that is high while the count sits on its last value.
module contador_modulo
  import paralelo_serial_flujo_pkg::*;
#(
  parameter int N       = ANCHO_DEF,
  parameter int ANCHO_C = ancho_cuenta(N),
  parameter int INICIO  = N - 1
) (
  input  logic               clk,
  input  logic               resetL,
  input  logic               en,
  output logic [ANCHO_C-1:0] cuenta,
  output logic               fin
);
  assign fin = (cuenta == ANCHO_C'(N - 1));

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL)  cuenta <= ANCHO_C'(INICIO);
    else if (en)  cuenta <= fin ? '0 : cuenta + ANCHO_C'(1);
  end
endmodule

// File: rtl/paralelo_serial_flujo.sv
// Parallel-to-serial converter with a one-word holding buffer; frames are
// free-running and an idle pattern fills every frame with no pending data.
module paralelo_serial_flujo
  import paralelo_serial_flujo_pkg::*;
#(
  parameter int               ANCHO       = ANCHO_DEF,
  parameter bit               MSB_PRIMERO = 1'b0,
  parameter logic [ANCHO-1:0] PATRON_IDLE = ANCHO'(K28_5_RDN)
) (
  input logic                   clk,
  input logic                   resetL,
  paralelo_serial_flujo_if.slave bus
);
  localparam int CW = ancho_cuenta(ANCHO);

  logic [CW-1:0]    cuenta, pos;
  logic             frontera, listo, acepta, lleno;
  logic [ANCHO-1:0] buffer, palabra, carga;
  logic             salida_q, inicio_q, enviando_q;

  contador_modulo #(.N(ANCHO), .ANCHO_C(CW), .INICIO(ANCHO - 1)) u_cnt (
    .clk    (clk),
    .resetL (resetL),
    .en     (1'b1),
    .cuenta (cuenta),
    .fin    (frontera)
  );

  // Ready depends only on registers: a full buffer drains on the boundary edge.
  assign listo  = !lleno || frontera;
  assign acepta = bus.validEntrada && listo;
  assign carga  = lleno ? buffer : PATRON_IDLE;

  // Bit position carried by salida after the coming (non-boundary) edge.
  always_comb begin
    pos = cuenta + CW'(1);
    if (MSB_PRIMERO) pos = CW'(ANCHO - 2) - cuenta;
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      lleno      <= 1'b0;
      buffer     <= '0;
      palabra    <= '0;
      salida_q   <= 1'b0;
      inicio_q   <= 1'b0;
      enviando_q <= 1'b0;
    end else begin
      if (frontera) begin
        palabra    <= carga;
        enviando_q <= lleno;
        inicio_q   <= 1'b1;
        salida_q   <= MSB_PRIMERO ? carga[ANCHO-1] : carga[0];
      end else begin
        inicio_q   <= 1'b0;
        salida_q   <= palabra[pos];
      end
      if (acepta) begin
        buffer <= bus.entradas;
        lleno  <= 1'b1;
      end else if (frontera) begin
        lleno  <= 1'b0;
      end
    end
  end

  assign bus.listoEntrada  = listo;
  assign bus.salida        = salida_q;
  assign bus.inicioPalabra = inicio_q;
  assign bus.enviandoDatos = enviando_q;
endmodule
